if_fetch_handshake: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined CPU.
- Drives the ID stage; takes stall and pcsource/branch targets back from ID.
- Fetches from a variable-latency instruction memory over a req/ack handshake.
- Handles load-use stall by holding, not refetching; captures ID-stage redirects (one delay slot) even when the delay-slot fetch is still outstanding.

---
 rtl/if_fetch_handshake_pkg.sv | 34 +++
 rtl/if_fetch_handshake_if_id_reg.sv | 31 +++
 rtl/if_fetch_handshake.sv | 122 ++++++++++++
 tb/tb_if_fetch_handshake.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_handshake_pkg.sv
// Shared CPU definitions for the fetch stage: pcsource encodings, fetch FSM
// states, the bubble instruction word and the redirect-target selector.
package if_fetch_handshake_pkg;

  localparam logic [1:0] PCSRC_P4 = 2'b00;
  localparam logic [1:0] PCSRC_BR = 2'b01;
  localparam logic [1:0] PCSRC_JR = 2'b10;
  localparam logic [1:0] PCSRC_J  = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Only meaningful for a redirecting pcsource; PCSRC_P4 never reaches a capture.
  function automatic logic [31:0] select_target(
    input logic [1:0]  src,
    input logic [31:0] bpc,
    input logic [31:0] rpc,
    input logic [31:0] jpc
  );
    logic [31:0] t;
    case (src)
      PCSRC_BR: t = bpc;
      PCSRC_JR: t = rpc;
      PCSRC_J:  t = jpc;
      default:  t = bpc;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_fetch_handshake_if_id_reg.sv
// IF/ID pipeline register: load takes priority over bubble, otherwise holds.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = if_fetch_handshake_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc4_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc4   <= 32'h0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      pc4   <= pc4_in;
      inst  <= inst_in;
      valid <= 1'b1;
    end else if (bubble) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_handshake.sv
// Instruction fetch stage: PC, req/ack fetch FSM with a one-entry skid for
// stalls, and delay-slot redirect capture feeding the IF/ID register.
module if_fetch_handshake #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_fetch_handshake_pkg::NOP_INST
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid
);
  import if_fetch_handshake_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  pc4;
  logic [31:0]  next_pc;
  logic [31:0]  sel_target;
  logic         capture;
  logic         redirect_pend;
  logic [31:0]  redirect_pc_reg;
  logic [31:0]  skid_pc4_reg;
  logic [31:0]  skid_inst_reg;
  logic         skid_load;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  load_pc4;
  logic [31:0]  load_inst;

  assign PC         = pc_reg;
  assign imem_addr  = pc_reg;
  assign pc4        = pc_reg + 32'd4;
  assign sel_target = select_target(pcsource, bpc, rpc, jpc);
  assign capture    = id_valid && !stall && (pcsource != PCSRC_P4);

  // A capture in the same cycle as the delay slot completing bypasses the
  // pending register so the target is used immediately.
  assign next_pc = capture       ? sel_target :
                   redirect_pend ? redirect_pc_reg : pc4;

  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    skid_load   = 1'b0;
    load_pc4    = pc4;
    load_inst   = imem_rdata;
    case (state_reg)
      FETCH: begin
        imem_req = !Reset;
        if (!stall) begin
          ifid_load   = imem_ack;
          ifid_bubble = !imem_ack;
        end else if (imem_ack) begin
          skid_load  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          ifid_load  = 1'b1;
          load_pc4   = skid_pc4_reg;
          load_inst  = skid_inst_reg;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      redirect_pend   <= 1'b0;
      redirect_pc_reg <= 32'h0;
      skid_pc4_reg    <= 32'h0;
      skid_inst_reg   <= NOP_INST;
    end else begin
      state_reg <= state_next;
      // ifid_load marks the cycle in which next_pc is consumed.
      if (ifid_load) begin
        pc_reg        <= next_pc;
        redirect_pend <= 1'b0;
      end else if (capture) begin
        redirect_pend   <= 1'b1;
        redirect_pc_reg <= sel_target;
      end
      if (skid_load) begin
        skid_pc4_reg  <= pc4;
        skid_inst_reg <= imem_rdata;
      end
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk     (Clock),
    .rst     (Reset),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .pc4_in  (load_pc4),
    .inst_in (load_inst),
    .pc4     (id_pc4),
    .inst    (id_inst),
    .valid   (id_valid)
  );

endmodule

// File: tb/tb_if_fetch_handshake.sv
// Bench for if_fetch_handshake: directed scenarios plus randomized memory
// latency, stalls and redirects checked against an instruction-stream model.
module tb_if_fetch_handshake;
  import if_fetch_handshake_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC, id_pc4, id_inst;
  logic        id_valid;

  int total = 0;
  int bad   = 0;

  // stimulus configuration
  bit          rand_mode = 1'b0;
  bit          man_stall = 1'b0;
  logic [1:0]  man_pcsrc = 2'b00;
  logic [31:0] man_bpc   = 32'h0;
  int          cfg_ws    = 0;

  // memory and reference-model state
  int          waitc = 0;
  int          cur_ws = 0;
  logic [31:0] acked[$];
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] slot_tgt = 32'h0;
  bit          slot_pend = 1'b0;
  bit          prev_wait = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          deliv = 0;

  always #5 Clock = ~Clock;

  if_fetch_handshake #(.RESET_PC(RST_PC), .NOP_INST(NOP_INST)) dut (
    .Clock(Clock), .Reset(Reset), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC(PC), .id_pc4(id_pc4), .id_inst(id_inst),
    .id_valid(id_valid)
  );

  assert property (@(posedge Clock) disable iff (Reset)
    !(id_valid && !stall && pcsource != 2'b00 && dut.redirect_pend))
    else $error("FAIL double_capture: redirect captured while one is pending");

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C96_A55A;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF8;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs on every falling edge: plays the ID stage and the memory, and
  // checks each instruction as ID consumes it.
  task automatic drive_cycle();
    logic [31:0] tgt;
    if (Reset) begin
      stall = 1'b0; pcsource = 2'b00; imem_ack = 1'b0;
      waitc = 0; cur_ws = cfg_ws; acked.delete();
      exp_addr = RST_PC; slot_pend = 1'b0; prev_wait = 1'b0; prev_hold = 1'b0;
      return;
    end
    if (prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
    if (prev_hold) check("hold_no_req", {31'h0, imem_req}, 32'h0);
    if (!id_valid) check("bubble_inst", id_inst, NOP_INST);

    if (rand_mode) begin
      stall = ($urandom_range(0, 3) == 0);
      bpc = rand_target(); rpc = rand_target(); jpc = rand_target();
      if (id_valid && !stall)
        pcsource = (!slot_pend && $urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else
        pcsource = 2'($urandom_range(0, 3));
    end else begin
      stall = man_stall; pcsource = man_pcsrc;
      bpc = man_bpc; rpc = 32'h0; jpc = 32'h0;
    end

    if (id_valid && !stall) begin
      check("id_pc4", id_pc4, exp_addr + 32'd4);
      check("id_inst", id_inst, word_at(exp_addr));
      if (acked.size() == 0) check("fetch_seen", 32'h0, 32'h1);
      else check("fetch_addr", acked.pop_front(), exp_addr);
      deliv++;
      tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? rpc : jpc;
      if (slot_pend) begin
        exp_addr  = slot_tgt;
        slot_pend = 1'b0;
      end else begin
        exp_addr = exp_addr + 32'd4;
      end
      if (pcsource != 2'b00) begin
        slot_pend = 1'b1;
        slot_tgt  = tgt;
      end
    end

    prev_hold = 1'b0;
    if (imem_req) begin
      if (waitc >= cur_ws) begin
        imem_ack = 1'b1;
        imem_rdata = word_at(imem_addr);
        acked.push_back(imem_addr);
        waitc = 0;
        cur_ws = rand_mode ? $urandom_range(0, 3) : cfg_ws;
        prev_wait = 1'b0;
        prev_hold = stall;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom();
        waitc++;
        prev_wait = 1'b1;
        prev_addr = imem_addr;
      end
    end else begin
      imem_ack = 1'b0;
      waitc = 0;
      prev_wait = 1'b0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pc", PC, RST_PC);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("rst_inst", id_inst, NOP_INST);
    check("rst_pc4", id_pc4, 32'h0);
    check("first_addr", imem_addr, RST_PC);
    check("first_req", {31'h0, imem_req}, 32'h1);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clock);
        drive_cycle();
      end
    join_none

    // zero-wait memory: one instruction per cycle
    #3;
    cfg_ws = 0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("zw_addr", imem_addr, 32'(4 * k));
      check("zw_valid", {31'h0, id_valid}, 32'h1);
      check("zw_inst", id_inst, word_at(32'(4 * (k - 1))));
    end

    // two wait states: valid pattern 0,0,1 per fetch
    cfg_ws = 2;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int c = 1; c <= 3; c++) begin
        tick();
        if (c < 3) begin
          check("ws2_addr", imem_addr, 32'(4 * f));
          check("ws2_bubble", {31'h0, id_valid}, 32'h0);
        end else begin
          check("ws2_addr", imem_addr, 32'(4 * (f + 1)));
          check("ws2_valid", {31'h0, id_valid}, 32'h1);
          check("ws2_inst", id_inst, word_at(32'(4 * f)));
        end
      end
    end

    // stall while the fetch of 8 is acknowledged
    cfg_ws = 0;
    do_reset();
    tick(); tick();
    check("st_pc", PC, 32'h8);
    man_stall = 1'b1;
    tick();
    check("st_hold_req", {31'h0, imem_req}, 32'h0);
    check("st_hold_pc", PC, 32'h8);
    check("st_hold_pc4", id_pc4, 32'h8);
    tick();
    check("st_hold_req2", {31'h0, imem_req}, 32'h0);
    man_stall = 1'b0;
    tick();
    check("st_rel_inst", id_inst, word_at(32'h8));
    check("st_rel_addr", imem_addr, 32'hC);
    check("st_rel_req", {31'h0, imem_req}, 32'h1);

    // branch at 4, delay slot 8, zero-wait
    do_reset();
    tick(); tick();
    man_pcsrc = 2'b01; man_bpc = 32'h40;
    tick();
    check("br0_addr", imem_addr, 32'h40);
    check("br0_slot", id_pc4, 32'hC);
    man_pcsrc = 2'b00;
    tick();
    check("br0_tgt_inst", id_inst, word_at(32'h40));

    // same branch with three wait states: redirect held pending
    cfg_ws = 3;
    do_reset();
    repeat (8) tick();
    check("br3_pc", PC, 32'h8);
    check("br3_id", id_pc4, 32'h8);
    man_pcsrc = 2'b01; man_bpc = 32'h40;
    tick();
    man_pcsrc = 2'b00;
    check("br3_pend", {31'h0, dut.redirect_pend}, 32'h1);
    check("br3_bubble", {31'h0, id_valid}, 32'h0);
    check("br3_addr_hold", imem_addr, 32'h8);
    repeat (3) tick();
    check("br3_slot", id_pc4, 32'hC);
    check("br3_slot_inst", id_inst, word_at(32'h8));
    check("br3_addr", imem_addr, 32'h40);
    check("br3_pend_clr", {31'h0, dut.redirect_pend}, 32'h0);

    // reset in the middle of a request at 0x20
    cfg_ws = 2;
    do_reset();
    for (int i = 0; i < 200 && PC != 32'h20; i++) tick();
    check("reach_pc20", PC, 32'h20);
    do_reset();
    repeat (3) tick();
    check("rr_valid", {31'h0, id_valid}, 32'h1);
    check("rr_pc4", id_pc4, 32'h4);
    check("rr_inst", id_inst, word_at(32'h0));

    // randomized latency, stalls and redirects
    rand_mode = 1'b1;
    deliv = 0;
    do_reset();
    repeat (3000) @(posedge Clock);
    check("progress", {31'h0, deliv > 300}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
